// File: rtl/dmem_responder.sv
// Data-memory slave for the core's DMem port: fixed-latency request handling,
// byte/half/word lane writes into a word array, registered read data and ready pulse.
module dmem_responder #(
    parameter int ADDR_W      = 32,
    parameter int DATA_W      = 32,
    parameter int DEPTH_WORDS = 1024,
    parameter int LATENCY     = 2
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [ADDR_W-1:0] dmem_addr,
    input  logic              dmem_r_enable,
    input  logic              dmem_w_enable,
    input  logic [1:0]        dmem_w_size,
    input  logic [DATA_W-1:0] dmem_w_data,
    output logic [DATA_W-1:0] dmem_r_data,
    output logic              dmem_ready,
    output logic              dmem_err
);

    localparam int IDX_W = $clog2(DEPTH_WORDS);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_BUSY = 2'd1;
    localparam logic [1:0] ST_RESP = 2'd2;

    localparam logic [1:0] SZ_BYTE = 2'b00;
    localparam logic [1:0] SZ_HALF = 2'b01;
    localparam logic [1:0] SZ_WORD = 2'b10;

    logic [1:0]        state;
    logic [3:0]        count;
    logic [IDX_W-1:0]  cap_idx;
    logic [1:0]        cap_off;
    logic [1:0]        cap_size;
    logic [DATA_W-1:0] cap_data;
    logic              cap_write;

    logic [DATA_W-1:0] mem [DEPTH_WORDS];

    logic              any_en;
    logic [IDX_W-1:0]  req_idx;
    logic [1:0]        req_off;
    logic [1:0]        req_size;
    logic [DATA_W-1:0] req_data;
    logic              req_write;
    logic              enter_resp;
    logic              commit_write;
    logic [3:0]        lane_en;
    logic [DATA_W-1:0] lane_data;
    logic              unused_addr_bits;

    // Upper address bits alias onto the array.
    assign unused_addr_bits = ^dmem_addr[ADDR_W-1:IDX_W+2];

    // With LATENCY==1 the access completes on the accepting edge, before the
    // capture registers hold anything, so the live inputs stand in for them.
    always_comb begin
        // NOTE: every always_comb output gets a default first so no latch is inferred.
        any_en    = dmem_r_enable | dmem_w_enable;
        req_idx   = cap_idx;
        req_off   = cap_off;
        req_size  = cap_size;
        req_data  = cap_data;
        req_write = cap_write;
        if (state == ST_IDLE) begin
            req_idx   = dmem_addr[IDX_W+1:2];
            req_off   = dmem_addr[1:0];
            req_size  = dmem_w_size;
            req_data  = dmem_w_data;
            req_write = dmem_w_enable;
        end

        enter_resp = any_en &&
                     (((state == ST_IDLE) && (LATENCY == 1)) ||
                      ((state == ST_BUSY) && (count == 4'd1)));
        commit_write = enter_resp && req_write;

        lane_en   = 4'b0000;
        lane_data = req_data;
        case (req_size)
            SZ_BYTE: begin
                lane_en   = 4'b0001 << req_off;
                lane_data = {4{req_data[7:0]}};
            end
            SZ_HALF: begin
                lane_en   = req_off[1] ? 4'b1100 : 4'b0011;
                lane_data = {2{req_data[15:0]}};
            end
            SZ_WORD: lane_en = 4'b1111;
            default: lane_en = 4'b0000;
        endcase
    end

    // NOTE: the array is deliberately left out of reset; only control state is cleared.
    always_ff @(posedge clk) begin
        if (commit_write) begin
            for (int b = 0; b < 4; b++) begin
                if (lane_en[b]) mem[req_idx][8*b +: 8] <= lane_data[8*b +: 8];
            end
        end
    end

    // NOTE: sequential state uses non-blocking assignments only.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state       <= ST_IDLE;
            count       <= 4'd0;
            cap_idx     <= '0;
            cap_off     <= 2'd0;
            cap_size    <= 2'd0;
            cap_data    <= '0;
            cap_write   <= 1'b0;
            dmem_ready  <= 1'b0;
            dmem_err    <= 1'b0;
            dmem_r_data <= '0;
        end else begin
            dmem_ready <= enter_resp;
            dmem_err   <= enter_resp && (req_size == 2'b11) && req_write;
            if (enter_resp && !req_write) dmem_r_data <= mem[req_idx];

            case (state)
                ST_IDLE: begin
                    if (any_en) begin
                        cap_idx   <= dmem_addr[IDX_W+1:2];
                        cap_off   <= dmem_addr[1:0];
                        cap_size  <= dmem_w_size;
                        cap_data  <= dmem_w_data;
                        cap_write <= dmem_w_enable;
                        if (LATENCY == 1) begin
                            state <= ST_RESP;
                        end else begin
                            state <= ST_BUSY;
                            count <= 4'(LATENCY - 1);
                        end
                    end
                end
                ST_BUSY: begin
                    // A request withdrawn mid-flight is abandoned without side effects.
                    if (!any_en) begin
                        state <= ST_IDLE;
                        count <= 4'd0;
                    end else if (count == 4'd1) begin
                        state <= ST_RESP;
                        count <= 4'd0;
                    end else begin
                        count <= count - 4'd1;
                    end
                end
                ST_RESP: state <= ST_IDLE;
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule
